// File: rtl/uart_pkg.sv
// Shared definitions for the 6809-side UART transmit FIFO: drain FSM
// encoding, status/control bit positions and the default FIFO depth.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

    // status register bit positions
    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_ACTIVE = 3;
    localparam int ST_IRQEN  = 4;

    // control register bit positions
    localparam int CTL_FLUSH = 0;
    localparam int CTL_IRQEN = 1;

    localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single-bit level crossing into clk.
// Resets to 0 so an in-reset UART reads as not busy.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    // shift the async level through STAGES flops; MSB is the safe copy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sr <= '0;
        else        sr <= (sr << 1) | STAGES'(d);
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/uart_tx_fifo.sv
// Bus-side transmit buffer between 6809 decode and the UART TX path.
// Bytes pushed via the data chip-enable are drained one at a time into the
// UART by a small handshake FSM keyed off the synchronized busy flag.
// Optional FIFO-empty interrupt: define UART_TXFIFO_IRQ_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_RW,
    input  logic       i_fifo_data_ce,
    input  logic       i_fifo_ctrl_ce,
    input  logic [7:0] i_data,
    input  logic       i_uart_busy,
    output logic [7:0] o_uart_data,
    output logic       o_uart_start,
    output logic [7:0] o_status,
    output logic       o_IRQ
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              ovf;
    logic              irq_en;
    tx_state_t         state, state_next;
    logic              busy_s;
    logic              load;

    // bus strobes and their one-clock-delayed copies for edge detection
    logic wr_data, wr_ctrl, rd_ctrl;
    logic wr_data_q, wr_ctrl_q, rd_ctrl_q;
    logic push_rise, ctrl_rise, rd_fall, flush, push_ok;
    logic empty, full;

    assign wr_data = !i_RW & i_fifo_data_ce;
    assign wr_ctrl = !i_RW & i_fifo_ctrl_ce;
    assign rd_ctrl =  i_RW & i_fifo_ctrl_ce;

    sync_ff #(.STAGES(SYNC_STAGES)) u_busy_sync (
        .clk   (clk),
        .reset (reset),
        .d     (i_uart_busy),
        .q     (busy_s)
    );

    // register strobes so a long bus cycle produces a single action
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_data_q <= 1'b0;
            wr_ctrl_q <= 1'b0;
            rd_ctrl_q <= 1'b0;
        end else begin
            wr_data_q <= wr_data;
            wr_ctrl_q <= wr_ctrl;
            rd_ctrl_q <= rd_ctrl;
        end
    end

    assign push_rise = wr_data & !wr_data_q;
    assign ctrl_rise = wr_ctrl & !wr_ctrl_q;
    assign rd_fall   = !rd_ctrl & rd_ctrl_q;
    assign flush     = ctrl_rise & i_data[CTL_FLUSH];

    assign empty = (count == '0);
    assign full  = (count == (ADDR_W+1)'(DEPTH));
    // a pop on the same edge frees a slot, so a full FIFO still accepts
    assign push_ok = push_rise & (!full | load) & !flush;

    // storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= i_data;
    end

    // pointers and occupancy; flush overrides any same-edge push or pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (load)    rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push_ok, load})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // sticky overflow on a dropped byte; cleared once a status read ends
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              ovf <= 1'b0;
        else if (push_rise & full & !load & !flush) ovf <= 1'b1;
        else if (rd_fall)                        ovf <= 1'b0;
    end

    // drain FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // drain FSM: launch head byte, hold start until UART busy, wait it out
    always_comb begin
        state_next   = state;
        load         = 1'b0;
        o_uart_start = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !flush) begin
                    load       = 1'b1;
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                o_uart_start = 1'b1;
                if (busy_s) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!busy_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // byte presented to the UART, held until the engine returns to IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    o_uart_data <= 8'h00;
        else if (load) o_uart_data <= mem[rd_ptr];
    end

`ifdef UART_TXFIFO_IRQ_EN
    // interrupt enable loaded from control writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         irq_en <= 1'b0;
        else if (ctrl_rise) irq_en <= i_data[CTL_IRQEN];
    end

    // active-low IRQ once everything queued has been handed to the UART
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) o_IRQ <= 1'b1;
        else        o_IRQ <= !(irq_en & empty & (state == IDLE));
    end
`else
    assign irq_en = 1'b0;
    assign o_IRQ  = 1'b1;
`endif

    // status register, combinational from current state
    always_comb begin
        o_status            = 8'h00;
        o_status[ST_EMPTY]  = empty;
        o_status[ST_FULL]   = full;
        o_status[ST_OVF]    = ovf;
        o_status[ST_ACTIVE] = (state != IDLE);
        o_status[ST_IRQEN]  = irq_en;
    end

endmodule
